// File: rtl/sram_arbiter_pkg.sv
// Shared types and constants for the two-port SRAM arbiter.
// Optional build macro: SRAM_ARBITER_ROUND_ROBIN_EN (consumed by arb_pick only).
package sram_arbiter_pkg;

  localparam int DEF_ADDR_W = 32;
  localparam int DEF_DATA_W = 32;

  localparam logic ENABLE  = 1'b1;
  localparam logic DISABLE = 1'b0;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_BUSY = 2'd1,
    ARB_DONE = 2'd2
  } arb_state_e;

  // A port is requesting when it asks for either a read or a write.
  function automatic logic port_req(input logic re, input logic we);
    return re | we;
  endfunction

endpackage

// File: rtl/sram_arbiter_if.sv
// Bus bundle between the two requesters, the arbiter and the SRAM controller.
// master = requesters plus controller side, slave = the arbiter.
interface sram_arbiter_if
  import sram_arbiter_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
);

  // Requests are levels held until the port's ready is seen high; ready low freezes the requester.
  logic              p0_re, p0_we, p0_ready;
  logic [ADDR_W-1:0] p0_addr;
  logic [DATA_W-1:0] p0_wdata, p0_rdata;
  logic              p1_re, p1_we, p1_ready;
  logic [ADDR_W-1:0] p1_addr;
  logic [DATA_W-1:0] p1_wdata, p1_rdata;
  logic              mem_re, mem_we, mem_ready;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata, mem_rdata;
  arb_state_e        dbg_state;

  modport master (
    output p0_re, p0_we, p0_addr, p0_wdata,
    input  p0_rdata, p0_ready,
    output p1_re, p1_we, p1_addr, p1_wdata,
    input  p1_rdata, p1_ready,
    input  mem_re, mem_we, mem_addr, mem_wdata,
    output mem_rdata, mem_ready,
    input  dbg_state
  );

  modport slave (
    input  p0_re, p0_we, p0_addr, p0_wdata,
    output p0_rdata, p0_ready,
    input  p1_re, p1_we, p1_addr, p1_wdata,
    output p1_rdata, p1_ready,
    output mem_re, mem_we, mem_addr, mem_wdata,
    input  mem_rdata, mem_ready,
    output dbg_state
  );

endinterface

// File: rtl/sram_arbiter_arb_pick.sv
// Two-way winner select. With SRAM_ARBITER_ROUND_ROBIN_EN defined, contention
// alternates on last_grant; otherwise port 0 always wins.
module arb_pick (
  input  logic req0_i,
  input  logic req1_i,
  input  logic last_grant_i,
  output logic grant_o
);

`ifdef SRAM_ARBITER_ROUND_ROBIN_EN
  always_comb begin
    grant_o = req1_i & ~req0_i;
    if (req0_i && req1_i) grant_o = ~last_grant_i;
  end
`else
  logic unused_last_grant;
  assign unused_last_grant = last_grant_i;
  assign grant_o = req1_i & ~req0_i;
`endif

endmodule

// File: rtl/sram_arbiter.sv
// Shares one SRAM controller between two requesters: latches the winner,
// holds it stable on the controller until completion, returns read data.
module sram_arbiter
  import sram_arbiter_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic          clk,
  input  logic          rst,
  sram_arbiter_if.slave bus
);

  arb_state_e        state_q;
  logic              owner_q, op_rd_q, last_grant_q, first_q;
  logic              mem_re_q, mem_we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q, p0_rdata_q, p1_rdata_q;

  logic              req0, req1, grant, sel_re;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;

  assign req0 = port_req(bus.p0_re, bus.p0_we);
  assign req1 = port_req(bus.p1_re, bus.p1_we);

  arb_pick u_pick (
    .req0_i      (req0),
    .req1_i      (req1),
    .last_grant_i(last_grant_q),
    .grant_o     (grant)
  );

  // Read wins when a port raises re and we together.
  assign sel_re    = grant ? bus.p1_re    : bus.p0_re;
  assign sel_addr  = grant ? bus.p1_addr  : bus.p0_addr;
  assign sel_wdata = grant ? bus.p1_wdata : bus.p0_wdata;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ARB_IDLE;
      owner_q      <= 1'b0;
      op_rd_q      <= 1'b0;
      last_grant_q <= 1'b1;
      first_q      <= 1'b0;
      mem_re_q     <= DISABLE;
      mem_we_q     <= DISABLE;
      addr_q       <= '0;
      wdata_q      <= '0;
      p0_rdata_q   <= '0;
      p1_rdata_q   <= '0;
    end else begin
      case (state_q)
        ARB_IDLE: begin
          if (req0 || req1) begin
            owner_q  <= grant;
            op_rd_q  <= sel_re;
            addr_q   <= sel_addr;
            wdata_q  <= sel_wdata;
            mem_re_q <= sel_re;
            mem_we_q <= ~sel_re;
            first_q  <= 1'b1;
            state_q  <= ARB_BUSY;
          end
        end
        ARB_BUSY: begin
          first_q <= 1'b0;
          // The controller still sits in its own IDLE on our first BUSY cycle and reports ready.
          if (!first_q && bus.mem_ready) begin
            if (op_rd_q) begin
              if (owner_q) p1_rdata_q <= bus.mem_rdata;
              else         p0_rdata_q <= bus.mem_rdata;
            end
            last_grant_q <= owner_q;
            mem_re_q     <= DISABLE;
            mem_we_q     <= DISABLE;
            state_q      <= ARB_DONE;
          end
        end
        ARB_DONE: state_q <= ARB_IDLE;
        default:  state_q <= ARB_IDLE;
      endcase
    end
  end

  assign bus.mem_re    = mem_re_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.p0_rdata  = p0_rdata_q;
  assign bus.p1_rdata  = p1_rdata_q;
  assign bus.dbg_state = state_q;

  // Only the request path is combinational; the DONE/owner terms are registered.
  assign bus.p0_ready = ~req0 | ((state_q == ARB_DONE) & ~owner_q);
  assign bus.p1_ready = ~req1 | ((state_q == ARB_DONE) &  owner_q);

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed bench for sram_arbiter: vector table of single transactions plus
// hand-written reset, contention and dropped-request sequences.
module tb_sram_arbiter;
  import sram_arbiter_pkg::*;

  localparam int MEM_LAT  = 7;
  localparam int LATENCY  = MEM_LAT + 2;
  localparam int WE_BUSY  = MEM_LAT + 1;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  sram_arbiter_if bus ();

  sram_arbiter dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // Controller model: ready while idle, busy after an enable, ready again after MEM_LAT cycles.
  logic [31:0] mdl_mem [16];
  int          mdl_cnt = 0;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      mdl_cnt <= 0;
      for (int i = 0; i < 16; i++) mdl_mem[i] <= 32'h5A5A_0000 + i;
      mdl_mem[0] <= 32'hDEAD_BEEF;
      mdl_mem[2] <= 32'h0BAD_F00D;
    end else begin
      if (bus.mem_re || bus.mem_we) mdl_cnt <= mdl_cnt + 1;
      else                          mdl_cnt <= 0;
      if (bus.mem_we && mdl_cnt >= MEM_LAT) mdl_mem[bus.mem_addr[5:2]] <= bus.mem_wdata;
    end
  end

  assign bus.mem_ready = (mdl_cnt == 0) || (mdl_cnt >= MEM_LAT);
  assign bus.mem_rdata = mdl_mem[bus.mem_addr[5:2]];

  // Activity monitor on the controller side.
  int          re_trains = 0, we_cycles = 0, unstable = 0;
  logic        prev_re = 1'b0, prev_act = 1'b0;
  logic [31:0] prev_addr = '0, prev_wdata = '0;

  always @(posedge clk) begin
    prev_re    <= bus.mem_re;
    prev_act   <= bus.mem_re | bus.mem_we;
    prev_addr  <= bus.mem_addr;
    prev_wdata <= bus.mem_wdata;
    if (bus.mem_re && !prev_re) re_trains <= re_trains + 1;
    if (bus.mem_we) we_cycles <= we_cycles + 1;
    if ((bus.mem_re || bus.mem_we) && prev_act &&
        (bus.mem_addr != prev_addr || bus.mem_wdata != prev_wdata))
      unstable <= unstable + 1;
  end

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic ready_of(input int port);
    return (port != 0) ? bus.p1_ready : bus.p0_ready;
  endfunction

  function automatic logic [31:0] rdata_of(input int port);
    return (port != 0) ? bus.p1_rdata : bus.p0_rdata;
  endfunction

  task automatic set_req(input int port, input logic re, input logic we,
                         input logic [31:0] addr, input logic [31:0] wdata);
    if (port == 0) begin
      bus.p0_re = re; bus.p0_we = we; bus.p0_addr = addr; bus.p0_wdata = wdata;
    end else begin
      bus.p1_re = re; bus.p1_we = we; bus.p1_addr = addr; bus.p1_wdata = wdata;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    int          port;
    logic        re;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    int          exp_we_cycles;
    int          exp_re_trains;
  } vec_t;

  vec_t vecs [6];

  task automatic run_vec(input int idx, input vec_t v);
    int n, re0, we0, un0;
    string tag;
    tag = $sformatf("v%0d", idx);
    re0 = re_trains; we0 = we_cycles; un0 = unstable;
    set_req(v.port, v.re, v.we, v.addr, v.wdata);
    #1;
    check({tag, "_ready_drop"}, 32'(ready_of(v.port)), 32'd0);
    n = 0;
    while (n < 50) begin
      tick();
      n++;
      if (ready_of(v.port)) break;
    end
    check({tag, "_latency"}, n, LATENCY);
    check({tag, "_state_done"}, 32'(bus.dbg_state), 32'(ARB_DONE));
    check({tag, "_other_ready"}, 32'(ready_of(1 - v.port)), 32'd1);
    set_req(v.port, 1'b0, 1'b0, 32'h0, 32'h0);
    check({tag, "_rdata"}, rdata_of(v.port), v.exp_rdata);
    tick();
    check({tag, "_state_idle"}, 32'(bus.dbg_state), 32'(ARB_IDLE));
    check({tag, "_we_cycles"}, we_cycles - we0, v.exp_we_cycles);
    check({tag, "_re_trains"}, re_trains - re0, v.exp_re_trains);
    check({tag, "_stable"}, unstable - un0, 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int grants, n, glitches, re0, we0;
    logic saw_re, p1_hi;
    logic [31:0] exp_q [$];

    set_req(0, 1'b0, 1'b0, 32'h0, 32'h0);
    set_req(1, 1'b0, 1'b0, 32'h0, 32'h0);

    vecs[0] = '{0, 1'b1, 1'b0, 32'h400, 32'h0000_0000, 32'hDEAD_BEEF, 0, 1};
    vecs[1] = '{1, 1'b0, 1'b1, 32'h404, 32'h1234_5678, 32'h0000_0000, WE_BUSY, 0};
    vecs[2] = '{1, 1'b1, 1'b0, 32'h404, 32'h0000_0000, 32'h1234_5678, 0, 1};
    vecs[3] = '{0, 1'b1, 1'b1, 32'h408, 32'hAAAA_5555, 32'h0BAD_F00D, 0, 1};
    vecs[4] = '{0, 1'b0, 1'b1, 32'h40C, 32'hCAFE_F00D, 32'h0BAD_F00D, WE_BUSY, 0};
    vecs[5] = '{0, 1'b1, 1'b0, 32'h40C, 32'h0000_0000, 32'hCAFE_F00D, 0, 1};

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_mem_re", 32'(bus.mem_re), 32'd0);
    check("rst_p0_ready", 32'(bus.p0_ready), 32'd1);
    check("rst_p1_ready", 32'(bus.p1_ready), 32'd1);
    check("rst_p0_rdata", bus.p0_rdata, 32'd0);
    check("rst_mem_addr", bus.mem_addr, 32'd0);
    rst = 1'b1;
    repeat (2) tick();
    check("idle_after_rst", 32'(bus.dbg_state), 32'(ARB_IDLE));

    for (int i = 0; i < 6; i++) run_vec(i, vecs[i]);

    // Reset in the middle of a read
    set_req(0, 1'b1, 1'b0, 32'h400, 32'h0);
    repeat (3) tick();
    check("midrst_busy", 32'(bus.dbg_state), 32'(ARB_BUSY));
    check("midrst_re_before", 32'(bus.mem_re), 32'd1);
    rst = 1'b0;
    set_req(0, 1'b0, 1'b0, 32'h0, 32'h0);
    #1;
    check("midrst_mem_re", 32'(bus.mem_re), 32'd0);
    check("midrst_mem_we", 32'(bus.mem_we), 32'd0);
    check("midrst_state", 32'(bus.dbg_state), 32'(ARB_IDLE));
    check("midrst_p0_ready", 32'(bus.p0_ready), 32'd1);
    check("midrst_p1_ready", 32'(bus.p1_ready), 32'd1);
    check("midrst_p0_rdata", bus.p0_rdata, 32'd0);
    tick();
    rst = 1'b1;
    re0 = re_trains;
    repeat (3) tick();
    check("postrst_idle", 32'(bus.dbg_state), 32'(ARB_IDLE));
    check("postrst_no_re", re_trains - re0, 32'd0);

    // Contention with both ports holding read requests
`ifdef SRAM_ARBITER_ROUND_ROBIN_EN
    exp_q = '{32'd0, 32'd1, 32'd0};
`else
    exp_q = '{32'd0, 32'd0, 32'd0};
`endif
    we0 = we_cycles;
    set_req(0, 1'b1, 1'b0, 32'h400, 32'h0);
    set_req(1, 1'b1, 1'b0, 32'h408, 32'h0);
    grants = 0; saw_re = 1'b0; p1_hi = 1'b0;
    for (int c = 0; c < 100 && grants < 3; c++) begin
      tick();
      if (bus.p1_ready) p1_hi = 1'b1;
      if (bus.mem_re && !saw_re) begin
        check($sformatf("grant%0d", grants), 32'(bus.mem_addr == 32'h408), exp_q.pop_front());
        grants++;
      end
      saw_re = bus.mem_re;
    end
    check("contention_grants", grants, 32'd3);
    set_req(0, 1'b0, 1'b0, 32'h0, 32'h0);
    set_req(1, 1'b0, 1'b0, 32'h0, 32'h0);
    n = 0;
    while (bus.dbg_state != ARB_IDLE && n < 40) begin
      tick();
      n++;
    end
    check("contention_drain", 32'(n < 40), 32'd1);
    check("contention_no_we", we_cycles - we0, 32'd0);
    check("contention_p0_rdata", bus.p0_rdata, 32'hDEAD_BEEF);
`ifdef SRAM_ARBITER_ROUND_ROBIN_EN
    check("contention_p1_ready_seen", 32'(p1_hi), 32'd1);
    check("contention_p1_rdata", bus.p1_rdata, 32'h0BAD_F00D);
`else
    check("contention_p1_ready_seen", 32'(p1_hi), 32'd0);
    check("contention_p1_rdata", bus.p1_rdata, 32'h0000_0000);
`endif

    // Port 0 drops its read mid-transaction: it still completes and stores the data
    tick();
    set_req(1, 1'b0, 1'b1, 32'h410, 32'h1111_2222);
    n = 0;
    do begin tick(); n++; end while (!bus.p1_ready && n < 50);
    check("drop_wr_latency", n, LATENCY);
    set_req(1, 1'b0, 1'b0, 32'h0, 32'h0);
    tick();
    re0 = re_trains;
    set_req(0, 1'b1, 1'b0, 32'h410, 32'h0);
    repeat (3) tick();
    check("drop_ready_low", 32'(bus.p0_ready), 32'd0);
    set_req(0, 1'b0, 1'b0, 32'h0, 32'h0);
    glitches = 0; n = 0;
    while (bus.dbg_state != ARB_IDLE && n < 40) begin
      #1;
      if (!bus.p0_ready) glitches++;
      tick();
      n++;
    end
    check("drop_drain", 32'(n < 40), 32'd1);
    check("drop_no_glitch", glitches, 32'd0);
    check("drop_rdata", bus.p0_rdata, 32'h1111_2222);
    check("drop_re_trains", re_trains - re0, 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
